// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder with IDLE/RUN/DONE control.
// Adds two WIDTH-bit operands LSB first, one bit per clock, through a single
// full-adder cell made of two half adders whose carries are ORed together.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed overflow output ovf.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - request one addition (accepted in IDLE or DONE)
//   a, b   - addends, latched when start is accepted
//   busy   - high while the addition runs
//   done   - one-cycle pulse with the result valid
//   sum    - a+b modulo 2^WIDTH, held until the next completed addition
//   cout   - carry out of bit WIDTH-1, held like sum
//   ovf    - (SERIAL_ADDER_OVF_EN only) two's-complement overflow, held like sum
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  , output logic           ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] a_sr, a_sr_d;
  logic [WIDTH-1:0] b_sr, b_sr_d;
  logic [WIDTH-1:0] res_sr, res_sr_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             carry, carry_d;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, busy_d, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_d;
`endif

  // Full adder on the current LSBs: two half adders plus an OR of their carries
  logic ha1_s, ha1_c, fa_s, ha2_c, fa_c;
  assign ha1_s = a_sr[0] ^ b_sr[0];
  assign ha1_c = a_sr[0] & b_sr[0];
  assign fa_s  = ha1_s ^ carry;
  assign ha2_c = ha1_s & carry;
  assign fa_c  = ha1_c | ha2_c;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      a_sr   <= a_sr_d;
      b_sr   <= b_sr_d;
      res_sr <= res_sr_d;
      cnt    <= cnt_d;
      carry  <= carry_d;
      sum    <= sum_d;
      cout   <= cout_d;
      busy   <= busy_d;
      done   <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= ovf_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state;
    a_sr_d   = a_sr;
    b_sr_d   = b_sr;
    res_sr_d = res_sr;
    cnt_d    = cnt;
    carry_d  = carry;
    sum_d    = sum;
    cout_d   = cout;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf;
`endif
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sr_d   = a_sr >> 1;
        b_sr_d   = b_sr >> 1;
        res_sr_d = {fa_s, res_sr[WIDTH-1:1]};
        carry_d  = fa_c;
        cnt_d    = cnt + CW'(1);
        busy_d   = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          // Last bit: publish the result together with the done pulse
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = {fa_s, res_sr[WIDTH-1:1]};
          cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          // carry into the MSB is the carry flop at this point
          ovf_d   = carry ^ fa_c;
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed and random
// additions compared against plain integer arithmetic.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: W+1 bit integer sum, signed overflow from operand/result signs
  function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = ref_sum(x, y);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = ref_sum(x, y);
    chk({tag, "_sum"}, 32'(sum), 32'(s[W-1:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(s[W]));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(x, y)));
`endif
  endtask

  // One addition started from IDLE; optionally disturbs a/b/start during RUN
  task automatic do_add(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit disturb);
    int lat, busy_cnt;
    bit got;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_cnt = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (disturb) begin
        a = W'($urandom); b = W'($urandom); start = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(W));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check_result(tag, x, y);
    // done must be a single-cycle pulse
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] x, y, hs;
    logic         hc;
    int           done_cnt, last_done, b2b_gap_err;

    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, first one started right after reset release
    do_add("d5a33", 8'h5A, 8'h33, 1'b0);
    do_add("dff01", 8'hFF, 8'h01, 1'b0);
    do_add("d8080", 8'h80, 8'h80, 1'b0);
    do_add("d0000", 8'h00, 8'h00, 1'b0);
    do_add("dffff", 8'hFF, 8'hFF, 1'b0);
    do_add("d7f01", 8'h7F, 8'h01, 1'b0);

    // Operands changed during RUN, then result must hold while idle
    do_add("chg", 8'h10, 8'h22, 1'b1);
    hs = sum; hc = cout;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk("hold_sum", 32'(sum), 32'(hs));
      chk("hold_cout", 32'(cout), 32'(hc));
      chk("hold_busy", 32'(busy), 32'd0);
    end

    // Random additions, some with disturbance during RUN
    for (int i = 0; i < 24; i++) begin
      x = W'($urandom); y = W'($urandom);
      do_add("rnd", x, y, 1'($urandom));
    end

    // Start held high: back-to-back results every W+1 cycles
    @(negedge clk);
    a = 8'h01; b = 8'h02; start = 1'b1;
    done_cnt = 0; last_done = -1; b2b_gap_err = 0;
    for (int i = 0; i < 5 * (W + 1) + 2; i++) begin
      @(posedge clk); #1;
      if (done) begin
        chk("b2b_sum", 32'(sum), 32'h03);
        chk("b2b_cout", 32'(cout), 32'd0);
        if (last_done >= 0 && (i - last_done) != W + 1) b2b_gap_err++;
        last_done = i;
        done_cnt++;
      end
    end
    chk("b2b_gap", 32'(b2b_gap_err), 32'd0);
    chk("b2b_count", 32'(done_cnt), 32'd5);
    @(negedge clk);
    start = 1'b0;
    repeat (W + 3) @(posedge clk);

    // Reset during RUN: immediate clear, no done afterwards
    do_add("pre_rst", 8'hC3, 8'h5A, 1'b0);
    @(negedge clk);
    a = 8'h77; b = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_cnt++;
    end
    chk("post_rst_quiet", 32'(done_cnt), 32'd0);
    do_add("post_rst", 8'h77, 8'h11, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
